// File: rtl/vram_pkg.sv
// Shared definitions for the renderer VRAM port and renderer primitives.
// - Default VRAM word address / data widths.
// - Responder FSM state encoding.
// - RGB444 field offsets inside a 24-bit VRAM word (two pixels per word).
package vram_pkg;

  // Word address is {bank, line[9:0], column[8:0]}.
  localparam int unsigned VRAM_ADDR_WIDTH = 20;
  localparam int unsigned VRAM_DATA_WIDTH = 24;

  // Pixel packing: pixel 0 in the low 12 bits, pixel 1 in the high 12 bits.
  localparam int unsigned PIXEL_BITS = 12;
  localparam int unsigned PIX0_LSB   = 0;
  localparam int unsigned PIX1_LSB   = 12;
  // Channel offsets within one pixel.
  localparam int unsigned RED_LSB    = 8;
  localparam int unsigned GREEN_LSB  = 4;
  localparam int unsigned BLUE_LSB   = 0;

  typedef enum logic [2:0] {
    StIdle,
    StReadSetup,
    StReadWait,
    StWriteSetup,
    StWritePulse,
    StWriteHold
  } vram_state_e;

endpackage

// File: rtl/vram_request_slot.sv
// Single pending-request slot.
// Captures a one-cycle request pulse together with its payload, holds it as
// pending until the access engine clears it, and flags a dropped request.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   request          one-cycle request pulse
//   request_payload  payload sampled with the pulse
//   clear            engine has taken the slot this cycle
//   pending          slot holds an unserved request
//   payload          held payload
//   overrun          one-cycle flag: pulse dropped because slot was busy
module vram_request_slot #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             request,
  input  logic [WIDTH-1:0] request_payload,
  input  logic             clear,
  output logic             pending,
  output logic [WIDTH-1:0] payload,
  output logic             overrun
);

  logic             pending_q, pending_d;
  logic [WIDTH-1:0] payload_q, payload_d;

  // A pulse arriving on the clear edge refills the slot rather than overrunning.
  always_comb begin
    pending_d = pending_q;
    payload_d = payload_q;
    overrun   = 1'b0;
    if (request) begin
      if (pending_q && !clear) begin
        overrun = 1'b1;
      end else begin
        pending_d = 1'b1;
        payload_d = request_payload;
      end
    end else if (clear) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      payload_q <= '0;
    end else begin
      pending_q <= pending_d;
      payload_q <= payload_d;
    end
  end

  assign pending = pending_q;
  assign payload = payload_q;

endmodule

// File: rtl/vram_renderer_port.sv
// Renderer-side VRAM responder: turns read/write request pulses into timed
// accesses on an external asynchronous SRAM.
// Ports:
//   i_master_clk, i_reset               clock, asynchronous active-high reset
//   i_vram_read_*  / o_vram_read_*      read request in, data + valid strobe out
//   i_vram_write_* / o_vram_write_done  write request in, done strobe out
//   i_display_busy                      scan-out owns the bus; no new access
//   o_overrun                           sticky: request dropped (slot busy)
//   o_sram_*, i_sram_data_in            SRAM bus (strobes active-low)
module vram_renderer_port
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = VRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH         = VRAM_DATA_WIDTH,
  parameter int unsigned READ_WAIT_CYCLES   = 2,
  parameter int unsigned WRITE_PULSE_CYCLES = 2
) (
  input  logic                  i_master_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_vram_read_address,
  input  logic                  i_vram_read_request,
  output logic [DATA_WIDTH-1:0] o_vram_read_data,
  output logic                  o_vram_read_data_valid,
  input  logic [ADDR_WIDTH-1:0] i_vram_write_address,
  input  logic [DATA_WIDTH-1:0] i_vram_write_data,
  input  logic                  i_vram_write_request,
  output logic                  o_vram_write_done,
  input  logic                  i_display_busy,
  output logic                  o_overrun,
  output logic [ADDR_WIDTH-1:0] o_sram_address,
  output logic [DATA_WIDTH-1:0] o_sram_data_out,
  output logic                  o_sram_data_oe,
  input  logic [DATA_WIDTH-1:0] i_sram_data_in,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n
);

  localparam int unsigned MaxWait  = (READ_WAIT_CYCLES > WRITE_PULSE_CYCLES) ?
                                     READ_WAIT_CYCLES : WRITE_PULSE_CYCLES;
  localparam int unsigned CntWidth = $clog2(MaxWait) + 1;
  localparam int unsigned WrWidth  = ADDR_WIDTH + DATA_WIDTH;

  logic                  rd_pending, rd_clear, rd_overrun;
  logic [ADDR_WIDTH-1:0] rd_payload;
  logic                  wr_pending, wr_clear, wr_overrun;
  logic [WrWidth-1:0]    wr_payload;

  vram_request_slot #(.WIDTH(ADDR_WIDTH)) u_read_slot (
    .clk             (i_master_clk),
    .rst             (i_reset),
    .request         (i_vram_read_request),
    .request_payload (i_vram_read_address),
    .clear           (rd_clear),
    .pending         (rd_pending),
    .payload         (rd_payload),
    .overrun         (rd_overrun)
  );

  vram_request_slot #(.WIDTH(WrWidth)) u_write_slot (
    .clk             (i_master_clk),
    .rst             (i_reset),
    .request         (i_vram_write_request),
    .request_payload ({i_vram_write_address, i_vram_write_data}),
    .clear           (wr_clear),
    .pending         (wr_pending),
    .payload         (wr_payload),
    .overrun         (wr_overrun)
  );

  vram_state_e         state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                ce_n_d, oe_n_d, we_n_d, data_oe_d, valid_d, done_d;

  // Next state; the slot is cleared on the edge that starts its access.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_clear = 1'b0;
    wr_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!i_display_busy) begin
          if (rd_pending) begin
            state_d  = StReadSetup;
            rd_clear = 1'b1;
          end else if (wr_pending) begin
            state_d  = StWriteSetup;
            wr_clear = 1'b1;
          end
        end
      end
      StReadSetup: begin
        state_d = StReadWait;
        cnt_d   = CntWidth'(READ_WAIT_CYCLES - 1);
      end
      StReadWait: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntWidth'(1);
      end
      StWriteSetup: begin
        state_d = StWritePulse;
        cnt_d   = CntWidth'(WRITE_PULSE_CYCLES - 1);
      end
      StWritePulse: begin
        if (cnt_q == '0) state_d = StWriteHold;
        else             cnt_d   = cnt_q - CntWidth'(1);
      end
      StWriteHold: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state and registered, so the pins
  // never see decode glitches and track the state with no extra latency.
  always_comb begin
    ce_n_d    = (state_d == StIdle);
    oe_n_d    = !((state_d == StReadSetup) || (state_d == StReadWait));
    we_n_d    = (state_d != StWritePulse);
    data_oe_d = (state_d == StWriteSetup) || (state_d == StWritePulse) ||
                (state_d == StWriteHold);
    valid_d   = (state_q == StReadWait) && (cnt_q == '0);
    done_d    = (state_q == StWriteHold);
  end

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q                <= StIdle;
      cnt_q                  <= '0;
      o_sram_ce_n            <= 1'b1;
      o_sram_oe_n            <= 1'b1;
      o_sram_we_n            <= 1'b1;
      o_sram_data_oe         <= 1'b0;
      o_vram_read_data_valid <= 1'b0;
      o_vram_write_done      <= 1'b0;
      o_vram_read_data       <= '0;
      o_sram_address         <= '0;
      o_sram_data_out        <= '0;
      o_overrun              <= 1'b0;
    end else begin
      state_q                <= state_d;
      cnt_q                  <= cnt_d;
      o_sram_ce_n            <= ce_n_d;
      o_sram_oe_n            <= oe_n_d;
      o_sram_we_n            <= we_n_d;
      o_sram_data_oe         <= data_oe_d;
      o_vram_read_data_valid <= valid_d;
      o_vram_write_done      <= done_d;
      o_overrun              <= o_overrun | rd_overrun | wr_overrun;
      if (valid_d) o_vram_read_data <= i_sram_data_in;
      if (rd_clear) begin
        o_sram_address <= rd_payload;
      end else if (wr_clear) begin
        o_sram_address  <= wr_payload[WrWidth-1:DATA_WIDTH];
        o_sram_data_out <= wr_payload[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_vram_renderer_port.sv
// Self-checking bench for vram_renderer_port with a behavioural async SRAM
// and a scoreboard of expected read data / write results.
module tb_vram_renderer_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] rd_addr;
  logic        rd_req;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic [19:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_req;
  logic        wr_done;
  logic        busy;
  logic        overrun;
  logic [19:0] sram_addr;
  logic [23:0] sram_dout;
  logic        sram_doe;
  logic [23:0] sram_din;
  logic        ce_n, oe_n, we_n;

  vram_renderer_port dut (
    .i_master_clk           (clk),
    .i_reset                (rst),
    .i_vram_read_address    (rd_addr),
    .i_vram_read_request    (rd_req),
    .o_vram_read_data       (rd_data),
    .o_vram_read_data_valid (rd_valid),
    .i_vram_write_address   (wr_addr),
    .i_vram_write_data      (wr_data),
    .i_vram_write_request   (wr_req),
    .o_vram_write_done      (wr_done),
    .i_display_busy         (busy),
    .o_overrun              (overrun),
    .o_sram_address         (sram_addr),
    .o_sram_data_out        (sram_dout),
    .o_sram_data_oe         (sram_doe),
    .i_sram_data_in         (sram_din),
    .o_sram_ce_n            (ce_n),
    .o_sram_oe_n            (oe_n),
    .o_sram_we_n            (we_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // SRAM model
  logic [23:0] mem [int];

  always @(posedge clk) begin
    if (!rst && !ce_n && !we_n && sram_doe) mem[int'(sram_addr)] = sram_dout;
  end

  always @(negedge clk) begin
    if (!ce_n && !oe_n && mem.exists(int'(sram_addr))) sram_din = mem[int'(sram_addr)];
    else sram_din = 24'h0;
  end

  // Scoreboard
  logic [23:0] exp_rd_q [$];
  logic [43:0] exp_wr_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        n_cmp++;
        if (exp_rd_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_read: unexpected valid, data=%h, none expected", rd_data);
        end else begin
          logic [23:0] e;
          e = exp_rd_q.pop_front();
          if (rd_data !== e) begin
            n_err++;
            $display("FAIL sb_read: data=%h expected=%h", rd_data, e);
          end
        end
      end
      if (wr_done) begin
        n_cmp++;
        if (exp_wr_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_write: unexpected done, none expected");
        end else begin
          logic [43:0] e;
          logic [23:0] got;
          e = exp_wr_q.pop_front();
          got = mem.exists(int'(e[43:24])) ? mem[int'(e[43:24])] : 24'hxxxxxx;
          if (got !== e[23:0]) begin
            n_err++;
            $display("FAIL sb_write: mem[%h]=%h expected=%h", e[43:24], got, e[23:0]);
          end
        end
      end
      if (!oe_n && !we_n) begin
        n_cmp++;
        n_err++;
        $display("FAIL strobe_excl: oe_n=%b we_n=%b, required not both low", oe_n, we_n);
      end
    end
  end

  // Stimulus helpers (no comparisons inside)
  task automatic pulse_read(input logic [19:0] a);
    rd_addr = a; rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic pulse_write(input logic [19:0] a, input logic [23:0] d);
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  // Runs a fixed number of edges, recording first strobe edges and strobe widths.
  task automatic run(input int edges, output int rd_at, output int wr_at,
                     output int oe_low, output int we_low, output int doe_hi,
                     output int ce_low);
    rd_at = 0; wr_at = 0; oe_low = 0; we_low = 0; doe_hi = 0; ce_low = 0;
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk); #1;
      if (!oe_n)    oe_low++;
      if (!we_n)    we_low++;
      if (sram_doe) doe_hi++;
      if (!ce_n)    ce_low++;
      if (rd_valid && rd_at == 0) rd_at = k;
      if (wr_done && wr_at == 0)  wr_at = k;
    end
  endtask

  int ra, wa, ol, wl, dh, cl;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if ({ce_n, oe_n, we_n} !== 3'b111) begin
      n_err++; $display("FAIL reset_strobes: got=%b required=111", {ce_n, oe_n, we_n});
    end
    n_cmp++; if ({sram_doe, rd_valid, wr_done, overrun} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got=%b required=0000", {sram_doe, rd_valid, wr_done, overrun});
    end
    n_cmp++; if (rd_data !== 24'h0 || sram_addr !== 20'h0 || sram_dout !== 24'h0) begin
      n_err++;
      $display("FAIL reset_regs: rd_data=%h addr=%h dout=%h required 0", rd_data, sram_addr,
               sram_dout);
    end
  endtask

  task automatic test_read();
    exp_rd_q.push_back(24'hABC123);
    pulse_read(20'h12345);
    run(8, ra, wa, ol, wl, dh, cl);
    n_cmp++; if (ra != 4) begin n_err++; $display("FAIL read_latency: got=%0d required=4", ra); end
    n_cmp++; if (ol != 3) begin n_err++; $display("FAIL read_oe_width: got=%0d required=3", ol); end
    n_cmp++; if (wl != 0) begin n_err++; $display("FAIL read_we: got=%0d required=0", wl); end
    n_cmp++; if (rd_data !== 24'hABC123) begin
      n_err++; $display("FAIL read_hold: got=%h required=abc123", rd_data);
    end
  endtask

  task automatic test_write();
    exp_wr_q.push_back({20'h80001, 24'hF00F00});
    pulse_write(20'h80001, 24'hF00F00);
    run(8, ra, wa, ol, wl, dh, cl);
    n_cmp++; if (wa != 5) begin n_err++; $display("FAIL write_latency: got=%0d required=5", wa); end
    n_cmp++; if (wl != 2) begin n_err++; $display("FAIL write_we_width: got=%0d required=2", wl); end
    n_cmp++; if (dh != 4) begin n_err++; $display("FAIL write_doe_width: got=%0d required=4", dh); end
    n_cmp++; if (ol != 0) begin n_err++; $display("FAIL write_oe: got=%0d required=0", ol); end
  endtask

  task automatic test_back_to_back();
    exp_rd_q.push_back(24'hABC123);
    exp_wr_q.push_back({20'h00010, 24'h123456});
    rd_addr = 20'h12345; rd_req = 1'b1;
    wr_addr = 20'h00010; wr_data = 24'h123456; wr_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    run(14, ra, wa, ol, wl, dh, cl);
    n_cmp++; if (ra != 4) begin n_err++; $display("FAIL b2b_read_at: got=%0d required=4", ra); end
    n_cmp++; if (wa != 9) begin n_err++; $display("FAIL b2b_write_at: got=%0d required=9", wa); end
    n_cmp++; if (overrun !== 1'b0) begin
      n_err++; $display("FAIL b2b_overrun: got=%b required=0", overrun);
    end
  endtask

  task automatic test_display_busy();
    exp_wr_q.push_back({20'h00200, 24'h0A0B0C});
    busy = 1'b1;
    pulse_write(20'h00200, 24'h0A0B0C);
    run(10, ra, wa, ol, wl, dh, cl);
    n_cmp++; if (cl != 0 || wa != 0) begin
      n_err++; $display("FAIL busy_hold: ce_low=%0d done_at=%0d required 0/0", cl, wa);
    end
    busy = 1'b0;
    run(8, ra, wa, ol, wl, dh, cl);
    n_cmp++; if (wa != 5) begin n_err++; $display("FAIL busy_release: got=%0d required=5", wa); end
  endtask

  task automatic test_overrun();
    exp_wr_q.push_back({20'h00020, 24'hAAAAAA});
    busy = 1'b1;
    pulse_write(20'h00020, 24'hAAAAAA);
    pulse_write(20'h00021, 24'h555555);
    n_cmp++; if (overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_set: got=%b required=1", overrun);
    end
    run(3, ra, wa, ol, wl, dh, cl);
    busy = 1'b0;
    run(12, ra, wa, ol, wl, dh, cl);
    n_cmp++; if (wa != 5 || wl != 2) begin
      n_err++; $display("FAIL overrun_first: done_at=%0d we_low=%0d required 5/2", wa, wl);
    end
    n_cmp++; if (overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_sticky: got=%b required=1", overrun);
    end
    n_cmp++; if (mem.exists(32'h21)) begin
      n_err++; $display("FAIL overrun_drop: mem[00021]=%h required unwritten", mem[32'h21]);
    end
  endtask

  task automatic test_reset_mid_write();
    pulse_write(20'h00030, 24'h777777);
    run(2, ra, wa, ol, wl, dh, cl);
    n_cmp++; if (we_n !== 1'b0) begin
      n_err++; $display("FAIL midrst_pre: we_n=%b required=0", we_n);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ce_n, we_n, sram_doe} !== 3'b110) begin
      n_err++; $display("FAIL midrst_strobes: got=%b required=110", {ce_n, we_n, sram_doe});
    end
    @(posedge clk); #1 rst = 1'b0;
    run(10, ra, wa, ol, wl, dh, cl);
    n_cmp++; if (wa != 0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL midrst_nodone: done_at=%0d overrun=%b required 0/0", wa, overrun);
    end
    exp_rd_q.push_back(24'hF00F00);
    pulse_read(20'h80001);
    run(8, ra, wa, ol, wl, dh, cl);
    n_cmp++; if (ra != 4) begin n_err++; $display("FAIL midrst_read: got=%0d required=4", ra); end
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; busy = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    mem[32'h12345] = 24'hABC123;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_display_busy();
    test_overrun();
    test_reset_mid_write();
    n_cmp++; if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: rd_left=%0d wr_left=%0d required 0/0", exp_rd_q.size(),
               exp_wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
